// File: rtl/fib_pkg.sv
// Shared types and reset values for the Fibonacci recurrence engine.
package fib_pkg;

  // Engine states. The encoding is also visible on the debug state port.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fib_state_e;

  // Values the registered outputs take while rst_n is low.
  localparam fib_state_e RST_STATE     = ST_IDLE;
  localparam logic       RST_CMD_READY = 1'b1;
  localparam logic       RST_RES_VALID = 1'b0;
  localparam logic       RST_BUSY      = 1'b0;
  localparam logic       RST_OVERFLOW  = 1'b0;
  localparam logic       RST_ERROR     = 1'b0;

endpackage : fib_pkg

// File: rtl/fib_addmod.sv
// Combinational add with optional single-step modular reduction.
// In modular mode both operands are below the modulus, so their sum is
// below 2*modulus and one conditional subtraction brings it back in range.
module fib_addmod #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] modulus,
  input  logic             mod_en,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] sum_red;

  // Full-width sum, its reduced form, and the mode select.
  always_comb begin
    sum_full = {1'b0, a} + {1'b0, b};
    // The reduced value is below the modulus, so WIDTH-bit wrap is exact.
    sum_red  = sum_full[WIDTH-1:0] - modulus;
    if (mod_en) begin
      sum   = (sum_full >= {1'b0, modulus}) ? sum_red : sum_full[WIDTH-1:0];
      carry = 1'b0;
    end else begin
      sum   = sum_full[WIDTH-1:0];
      carry = sum_full[WIDTH];
    end
  end

endmodule : fib_addmod

// File: rtl/fib_engine.sv
// Iterative Fibonacci recurrence engine: fib(n,a,b) = n==0 ? a : fib(n-1,b,a+b).
// One iteration per cycle, optional modular arithmetic, per-register overflow
// tracking, seed/modulus checking and abort.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high. cmd_ready is high only in IDLE; res_valid is high only in DONE and,
// once raised, stays high with stable result/overflow/error until res_ready.
module fib_engine
  import fib_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int N_WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [N_WIDTH-1:0] init_n,
  input  logic [WIDTH-1:0]   init_a,
  input  logic [WIDTH-1:0]   init_b,
  input  logic               mod_en,
  input  logic [WIDTH-1:0]   modulus,
  input  logic               abort,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH-1:0]   result,
  output logic               overflow,
  output logic               error,
  output logic               busy,
  output fib_state_e         dbg_state
);

  localparam logic [N_WIDTH-1:0] CNT_ONE = N_WIDTH'(1);

  fib_state_e         state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   mod_val_q, mod_val_d;
  logic               mod_en_q, mod_en_d;
  logic [N_WIDTH-1:0] cnt_q, cnt_d;
  logic               ovf_a_q, ovf_a_d;
  logic               ovf_b_q, ovf_b_d;
  logic               err_q, err_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               res_valid_q, res_valid_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               overflow_q, overflow_d;
  logic               error_q, error_d;

  logic [WIDTH-1:0]   step_sum;
  logic               step_carry;
  logic               bad_cmd;

  fib_addmod #(.WIDTH(WIDTH)) u_addmod (
    .a       (a_q),
    .b       (b_q),
    .modulus (mod_val_q),
    .mod_en  (mod_en_q),
    .sum     (step_sum),
    .carry   (step_carry)
  );

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    mod_val_d   = mod_val_q;
    mod_en_d    = mod_en_q;
    cnt_d       = cnt_q;
    ovf_a_d     = ovf_a_q;
    ovf_b_d     = ovf_b_q;
    err_d       = err_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    error_d     = error_q;
    bad_cmd     = mod_en && ((modulus == '0) || (init_a >= modulus) ||
                             (init_b >= modulus));

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          a_d       = init_a;
          b_d       = init_b;
          cnt_d     = init_n;
          mod_en_d  = mod_en;
          mod_val_d = modulus;
          ovf_a_d   = 1'b0;
          ovf_b_d   = 1'b0;
          err_d     = 1'b0;
          if (bad_cmd) begin
            // Rejected command: present a zero result flagged as error.
            err_d      = 1'b1;
            a_d        = '0;
            result_d   = '0;
            overflow_d = 1'b0;
            error_d    = 1'b1;
            state_d    = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          // Abort beats completion when both happen in the same cycle.
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          result_d   = a_q;
          overflow_d = ovf_a_q;
          error_d    = err_q;
          state_d    = ST_DONE;
        end else begin
          a_d     = b_q;
          b_d     = step_sum;
          ovf_a_d = ovf_b_q;
          ovf_b_d = ovf_a_q | ovf_b_q | step_carry;
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    res_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      a_q         <= '0;
      b_q         <= '0;
      mod_val_q   <= '0;
      mod_en_q    <= 1'b0;
      cnt_q       <= '0;
      ovf_a_q     <= 1'b0;
      ovf_b_q     <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= RST_CMD_READY;
      res_valid_q <= RST_RES_VALID;
      busy_q      <= RST_BUSY;
      result_q    <= '0;
      overflow_q  <= RST_OVERFLOW;
      error_q     <= RST_ERROR;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mod_val_q   <= mod_val_d;
      mod_en_q    <= mod_en_d;
      cnt_q       <= cnt_d;
      ovf_a_q     <= ovf_a_d;
      ovf_b_q     <= ovf_b_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      error_q     <= error_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign error     = error_q;
  assign dbg_state = state_q;

endmodule : fib_engine

// File: tb/tb_fib_engine.sv
// Testbench for fib_engine: a 32-bit and an 8-bit instance share one driver;
// sel8 picks which instance a command goes to and whose outputs are observed.
module tb_fib_engine;
  import fib_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic        sel8;
  logic        cmd_valid;
  logic        res_ready;
  logic        abort;
  logic        mod_en;
  logic [5:0]  init_n;
  logic [31:0] init_a, init_b, modulus;

  // 32-bit instance outputs
  logic        cmd_ready32, res_valid32, overflow32, error32, busy32;
  logic [31:0] result32;
  fib_state_e  state32;
  // 8-bit instance outputs
  logic        cmd_ready8, res_valid8, overflow8, error8, busy8;
  logic [7:0]  result8;
  fib_state_e  state8;

  // Observed (selected) outputs
  logic        cmd_ready_m, res_valid_m, overflow_m, error_m, busy_m;
  logic [31:0] result_m;
  assign cmd_ready_m = sel8 ? cmd_ready8 : cmd_ready32;
  assign res_valid_m = sel8 ? res_valid8 : res_valid32;
  assign overflow_m  = sel8 ? overflow8  : overflow32;
  assign error_m     = sel8 ? error8     : error32;
  assign busy_m      = sel8 ? busy8      : busy32;
  assign result_m    = sel8 ? {24'd0, result8} : result32;

  fib_engine #(.WIDTH(32), .N_WIDTH(6)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid & ~sel8), .cmd_ready(cmd_ready32),
    .init_n(init_n), .init_a(init_a), .init_b(init_b),
    .mod_en(mod_en), .modulus(modulus), .abort(abort & ~sel8),
    .res_valid(res_valid32), .res_ready(res_ready & ~sel8),
    .result(result32), .overflow(overflow32), .error(error32),
    .busy(busy32), .dbg_state(state32)
  );

  fib_engine #(.WIDTH(8), .N_WIDTH(6)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid & sel8), .cmd_ready(cmd_ready8),
    .init_n(init_n), .init_a(init_a[7:0]), .init_b(init_b[7:0]),
    .mod_en(mod_en), .modulus(modulus[7:0]), .abort(abort & sel8),
    .res_valid(res_valid8), .res_ready(res_ready & sel8),
    .result(result8), .overflow(overflow8), .error(error8),
    .busy(busy8), .dbg_state(state8)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  // {error, overflow, result[31:0]}
  logic [33:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: iterate the recurrence with exact (unbounded) integers, then
  // reduce. Overflow means the exact final a does not fit in w bits.
  function automatic logic [33:0] ref_fib(input int w, input int n,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic men, input logic [31:0] m);
    logic [127:0] x, y, t, lim, r;
    logic         ovf;
    if (men && (m == 0 || a >= m || b >= m)) return {1'b1, 1'b0, 32'd0};
    x   = 128'(a);
    y   = 128'(b);
    lim = 128'd1 << w;
    for (int i = 0; i < n; i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    if (men) begin
      r   = x % 128'(m);
      ovf = 1'b0;
    end else begin
      r   = x % lim;
      ovf = (x >= lim);
    end
    return {1'b0, ovf, r[31:0]};
  endfunction

  // ---------------- driver tasks ----------------
  // Issue one command, wait for its result, optionally stall the consumer
  // (with abort pulsed while stalled when abort_in_done), then hand it off.
  task automatic run_cmd(input logic s8, input int n, input logic [31:0] a,
                         input logic [31:0] b, input logic men, input logic [31:0] m,
                         input int hold, input logic abort_in_done);
    logic [33:0] e;
    int          edges;
    int          w;
    logic [31:0] msk;
    w   = s8 ? 8 : 32;
    msk = s8 ? 32'h0000_00ff : 32'hffff_ffff;
    @(negedge clk);
    sel8      = s8;
    init_n    = 6'(n);
    init_a    = a & msk;
    init_b    = b & msk;
    mod_en    = men;
    modulus   = m & msk;
    cmd_valid = 1'b1;
    check("cmd_ready_idle", 64'(cmd_ready_m), 64'(1));
    exp_q.push_back(ref_fib(w, n, a & msk, b & msk, men, m & msk));
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    // Inputs after acceptance must not matter.
    init_n  = 6'($urandom_range(0, 63));
    init_a  = $urandom;
    init_b  = $urandom;
    mod_en  = 1'($urandom_range(0, 1));
    modulus = $urandom;
    edges = 1;
    while (!res_valid_m && edges < 200) begin
      @(negedge clk);
      edges++;
    end
    e = exp_q.pop_front();
    if (e[33]) check("err_latency", 64'(edges), 64'(1));
    else       check("latency", 64'(edges - 1), 64'(n + 1));
    check("result", 64'(result_m), 64'(e[31:0]));
    check("overflow", 64'(overflow_m), 64'(e[32]));
    check("error", 64'(error_m), 64'(e[33]));
    if (abort_in_done) abort = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(res_valid_m), 64'(1));
      check("hold_result", 64'(result_m), 64'(e[31:0]));
      check("hold_flags", 64'({error_m, overflow_m}), 64'({e[33], e[32]}));
      check("hold_cmd_ready", 64'(cmd_ready_m), 64'(0));
    end
    abort     = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("handoff_valid", 64'(res_valid_m), 64'(0));
    check("handoff_cmd_ready", 64'(cmd_ready_m), 64'(1));
  endtask

  // Accept fib(50,0,1) on the 32-bit instance and leave it running.
  task automatic start_long();
    @(negedge clk);
    sel8      = 1'b0;
    init_n    = 6'd50;
    init_a    = 32'd0;
    init_b    = 32'd1;
    mod_en    = 1'b0;
    modulus   = 32'd0;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 64'(cmd_ready_m), 64'(1));
    check({tag, "_res_valid"}, 64'(res_valid_m), 64'(0));
    check({tag, "_busy"}, 64'(busy_m), 64'(0));
    check({tag, "_result"}, 64'(result_m), 64'(0));
    check({tag, "_flags"}, 64'({error_m, overflow_m}), 64'(0));
    check({tag, "_state"}, 64'(state32), 64'(ST_IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          seen;
    int          s8, n, men;
    logic [31:0] a, b, m;

    rst_n = 1'b0; sel8 = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0; abort = 1'b0;
    mod_en = 1'b0; init_n = '0; init_a = '0; init_b = '0; modulus = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Directed cases
    run_cmd(1'b0, 10, 32'd0, 32'd1, 1'b0, 32'd0, 0, 1'b0);  // 55
    run_cmd(1'b0, 0,  32'd7, 32'd9, 1'b0, 32'd0, 0, 1'b0);  // 7
    run_cmd(1'b0, 1,  32'd7, 32'd9, 1'b0, 32'd0, 0, 1'b0);  // 9
    run_cmd(1'b1, 13, 32'd0, 32'd1, 1'b0, 32'd0, 0, 1'b0);  // 233, no overflow
    run_cmd(1'b1, 14, 32'd0, 32'd1, 1'b0, 32'd0, 0, 1'b0);  // 121, overflow
    run_cmd(1'b0, 10, 32'd0, 32'd1, 1'b1, 32'd7, 0, 1'b0);  // 6
    run_cmd(1'b0, 10, 32'd0, 32'd1, 1'b1, 32'd0, 0, 1'b0);  // error
    run_cmd(1'b0, 10, 32'd7, 32'd1, 1'b1, 32'd7, 0, 1'b0);  // error
    run_cmd(1'b0, 63, 32'hffff_ffff, 32'hffff_ffff, 1'b0, 32'd0, 0, 1'b0);
    run_cmd(1'b0, 4,  32'd2, 32'd3, 1'b0, 32'd0, 5, 1'b0);  // consumer stall
    run_cmd(1'b0, 5,  32'd1, 32'd1, 1'b0, 32'd0, 0, 1'b0);  // next command accepted
    run_cmd(1'b0, 2,  32'd1, 32'd1, 1'b0, 32'd0, 3, 1'b1);  // abort ignored in DONE

    // Abort at RUN cycle 3
    start_long();
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_cmd_ready", 64'(cmd_ready_m), 64'(1));
    check("abort_busy", 64'(busy_m), 64'(0));
    check("abort_state", 64'(state32), 64'(ST_IDLE));
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (res_valid_m) seen++;
    end
    check("abort_no_result", 64'(seen), 64'(0));

    // Asynchronous reset in the middle of RUN
    run_cmd(1'b0, 6, 32'd1, 32'd2, 1'b0, 32'd0, 0, 1'b0);  // leaves result nonzero
    start_long();
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(1'b0, 3, 32'd0, 32'd1, 1'b0, 32'd0, 0, 1'b0);  // 2

    // Randomized commands against the reference model
    for (int k = 0; k < 40; k++) begin
      s8  = $urandom_range(0, 1);
      n   = $urandom_range(0, 63);
      men = $urandom_range(0, 2) == 0 ? 1 : 0;
      a   = $urandom;
      b   = $urandom;
      m   = (s8 != 0) ? $urandom_range(0, 255) : $urandom;
      if (men != 0 && $urandom_range(0, 4) != 0 && (m & ((s8 != 0) ? 32'hff : 32'hffff_ffff)) != 0) begin
        m = m & ((s8 != 0) ? 32'hff : 32'hffff_ffff);
        a = a % m;
        b = b % m;
      end
      run_cmd(1'(s8), n, a, b, 1'(men), m, $urandom_range(0, 3), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fib_engine
